// File: rtl/reg_rd_pkg.sv
// Shared types and helpers for the result-register serial reader.
package reg_rd_pkg;

    // Transfer state; StPar is only reachable when the parity bit is built in.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StPar   = 2'd2,
        StDone  = 2'd3
    } rd_state_e;

    localparam int unsigned DefaultWidth = 32;

    // Bit-counter width: clog2 of the word width, at least one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// Parallel-load, serial-out shift register. Load wins over shift; vacated bits fill with 0.
module shift_reg_piso #(
    parameter int unsigned Width    = 32,
    parameter bit          MsbFirst = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [Width-1:0] d_i,
    output logic             ser_o
);

    logic [Width-1:0] data_q, data_d;

    // Next word: capture, shift toward the output end, or hold.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = d_i;
        end else if (shift_i) begin
            data_d = MsbFirst ? {data_q[Width-2:0], 1'b0} : {1'b0, data_q[Width-1:1]};
        end
    end

    // Shift register state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign ser_o = MsbFirst ? data_q[Width-1] : data_q[0];

endmodule

// File: rtl/reg32_serial_reader.sv
// Serial read-out of a result register word under a valid/ready handshake.
// Optional even-parity trailer bit: define REG32_SERIAL_READER_PARITY_EN.
module reg32_serial_reader
    import reg_rd_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] d_in,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    rd_state_e       state_q, state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic            load, shift, piso_bit;
`ifdef REG32_SERIAL_READER_PARITY_EN
    logic            parity_q, parity_d;
`endif

    shift_reg_piso #(
        .Width    (WIDTH),
        .MsbFirst (MSB_FIRST)
    ) u_piso (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .load_i  (load),
        .shift_i (shift),
        .d_i     (d_in),
        .ser_o   (piso_bit)
    );

    // Next-state, counter and parity update; ser_ready only counts while a bit is presented.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        load      = 1'b0;
        shift     = 1'b0;
`ifdef REG32_SERIAL_READER_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load      = 1'b1;
                    bit_cnt_d = '0;
`ifdef REG32_SERIAL_READER_PARITY_EN
                    parity_d  = 1'b0;
`endif
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (ser_ready) begin
                    shift = 1'b1;
`ifdef REG32_SERIAL_READER_PARITY_EN
                    parity_d = parity_q ^ piso_bit;
`endif
                    if (bit_cnt_q == LastBit) begin
                        // Counter holds on the last bit so it never wraps.
`ifdef REG32_SERIAL_READER_PARITY_EN
                        state_d = StPar;
`else
                        state_d = StDone;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StPar: begin
                if (ser_ready) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        ser_valid = (state_q == StShift) || (state_q == StPar);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        ser_out   = 1'b0;
        if (state_q == StShift) begin
            ser_out = piso_bit;
        end
`ifdef REG32_SERIAL_READER_PARITY_EN
        if (state_q == StPar) begin
            ser_out = parity_q;
        end
`endif
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
`ifdef REG32_SERIAL_READER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef REG32_SERIAL_READER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_reg32_serial_reader.sv
// Randomized bench for reg32_serial_reader: LSB-first and MSB-first instances share stimulus.
module tb_reg32_serial_reader;

    localparam int unsigned W = 32;
`ifdef REG32_SERIAL_READER_PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         ser_ready = 1'b0;
    logic [W-1:0] d_in = '0;
    logic         so_l, sv_l, busy_l, done_l;
    logic         so_m, sv_m, busy_m, done_m;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    bit           exp_l[$];
    bit           exp_m[$];

    always #5 clk = ~clk;

    reg32_serial_reader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .d_in      (d_in),
        .ser_ready (ser_ready),
        .ser_out   (so_l),
        .ser_valid (sv_l),
        .busy      (busy_l),
        .done      (done_l)
    );

    reg32_serial_reader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .d_in      (d_in),
        .ser_ready (ser_ready),
        .ser_out   (so_m),
        .ser_valid (sv_m),
        .busy      (busy_m),
        .done      (done_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_so_l"}, 32'(so_l), 0);
        check({tag, "_sv_l"}, 32'(sv_l), 0);
        check({tag, "_busy_l"}, 32'(busy_l), 0);
        check({tag, "_done_l"}, 32'(done_l), 0);
        check({tag, "_so_m"}, 32'(so_m), 0);
        check({tag, "_sv_m"}, 32'(sv_m), 0);
        check({tag, "_busy_m"}, 32'(busy_m), 0);
        check({tag, "_done_m"}, 32'(done_m), 0);
    endtask

    // mode 0: always ready; 1: random ready; 2: three stall cycles after 7 accepted bits.
    // abort_after >= 0: assert reset once that many bits have been accepted.
    task automatic run_xfer(input logic [W-1:0] word, input int mode, input int abort_after);
        int cyc = 0;
        int stalls = 0;
        int accepted = 0;
        int stall_cnt = 0;
        bit rdy;
        exp_l.delete();
        exp_m.delete();
        for (int i = 0; i < W; i++) begin
            exp_l.push_back(word[i]);
            exp_m.push_back(word[W-1-i]);
        end
        if (P == 1) begin
            exp_l.push_back(^word);
            exp_m.push_back(^word);
        end
        @(negedge clk);
        check("idle_busy", 32'(busy_l | busy_m), 0);
        d_in  = word;
        start = 1'b1;
        ser_ready = 1'b1;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc > 300) begin
                check("timeout", 1, 0);
                break;
            end
            if (exp_l.size() == 0) begin
                check("done_l", 32'(done_l), 1);
                check("done_m", 32'(done_m), 1);
                check("done_busy", 32'({busy_l, busy_m}), 3);
                check("done_valid", 32'({sv_l, sv_m}), 0);
                check("done_cycle", cyc, W + 1 + P + stalls);
                break;
            end
            check("valid", 32'({sv_l, sv_m}), 3);
            check("busy", 32'({busy_l, busy_m}), 3);
            check("no_done", 32'({done_l, done_m}), 0);
            check("bit_lsb", 32'(so_l), 32'(exp_l[0]));
            check("bit_msb", 32'(so_m), 32'(exp_m[0]));
            if (abort_after >= 0 && accepted == abort_after) begin
                start   = 1'b0;
                reset_n = 1'b0;
                #1;
                check_quiet("abort");
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 2) != 0);
                default: begin
                    if (accepted == 7 && stall_cnt < 3) begin
                        rdy = 1'b0;
                        stall_cnt++;
                    end else begin
                        rdy = 1'b1;
                    end
                end
            endcase
            ser_ready = rdy;
            start     = ($urandom_range(0, 3) == 0);
            d_in      = $urandom;
            if (rdy) begin
                void'(exp_l.pop_front());
                void'(exp_m.pop_front());
                accepted++;
            end else begin
                stalls++;
            end
        end
        // start raised during the done cycle must be dropped.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_busy", 32'({busy_l, busy_m}), 0);
        check("post_valid", 32'({sv_l, sv_m}), 0);
        check("post_done", 32'({done_l, done_m}), 0);
    endtask

    initial begin
        #3;
        check_quiet("reset");
        @(negedge clk);
        reset_n = 1'b1;
        run_xfer(32'hA5A5_0001, 0, -1);
        run_xfer(32'hFFFF_FFFF, 0, -1);
        run_xfer(32'h0000_0000, 0, -1);
        run_xfer($urandom, 2, -1);
        run_xfer($urandom, 0, 5);
        run_xfer(32'h0000_0003, 0, -1);
        for (int n = 0; n < 20; n++) begin
            run_xfer($urandom, 1, -1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
